decode_stage: RTL and testbench
===============================

DECODE_STAGE -- requirements
Module: decode_stage

Interface
REQ-001 SHALL have parameter XLEN, default 32, datapath width; legal values 32 or 64.
REQ-002 SHALL have parameter EN_M, default 0, 1 = accept RV M-extension R-type encodings.
REQ-003 SHALL have parameter EN_CSR, default 1, 1 = decode SYSTEM/CSR encodings.
REQ-004 SHALL have port i_clk, input, 1, single clock; all state changes on its rising edge.
REQ-005 SHALL have port i_rst_n, input, 1; reset is asynchronous and active-low.
REQ-006 SHALL have port i_valid, input, 1, upstream instruction valid.
REQ-007 SHALL have port o_ready, output, 1, stage can accept an instruction.
REQ-008 SHALL have port i_inst, input, 32, instruction word.
REQ-009 SHALL have port i_pc, input, XLEN, instruction address.
REQ-010 SHALL have port i_flush, input, 1, discard held and incoming instruction.
REQ-011 SHALL have port o_valid, output, 1, decoded bundle valid.
REQ-012 SHALL have port i_ready, input, 1, downstream accepts bundle.
REQ-013 SHALL have ports o_pc (XLEN), o_rd, o_rs1, o_rs2 (5 each), o_funct3 (3), o_funct7 (7), outputs, registered fields.
REQ-014 SHALL have port o_imm, output, XLEN, sign-extended immediate.
REQ-015 SHALL have ports o_rfwe, o_mren, o_mwen, o_imm_rs, o_pc_rs, o_csrr, outputs, 1 each, registered controls.
REQ-016 SHALL have port o_ctrl, output, 4, ALU control.
REQ-017 SHALL have port o_illegal, output, 1, illegal-instruction flag, qualified by o_valid.

Function
REQ-018 SHALL register one decoded bundle; latency i_valid&o_ready to o_valid is exactly 1 cycle.
REQ-019 SHALL drive o_ready = !o_valid | i_ready; full throughput at one instruction per cycle.
REQ-020 SHALL hold every output stable while o_valid=1 and i_ready=0.
REQ-021 SHALL, on i_flush=1, clear o_valid next cycle regardless of i_valid/i_ready; flush has priority over load.
REQ-022 SHALL sign-extend immediates from inst[31]: I, S, B (bit0=0), U (inst[31:12]<<12), J (bit0=0); shift-immediates yield zero-extended shamt (5 bits if XLEN=32, 6 bits if XLEN=64); CSR yields zero-extended inst[19:15]; R-type yields 0.
REQ-023 SHALL force o_rfwe=0 when rd=0, for store, and for branch.
REQ-024 SHALL assert o_illegal when inst[1:0]!=2'b11, opcode is unknown, R-type funct7 is not 0x00/0x20 (or 0x01 with EN_M=1), SRAI/SRLI upper imm bits are invalid, or SYSTEM appears with EN_CSR=0.
REQ-025 SHALL zero o_rfwe, o_mren, and o_mwen on illegal instructions.
REQ-026 SHALL drive o_pc_rs=1 for AUIPC/JAL/JALR; o_imm_rs=1 for load, store, OP-IMM, JALR, and JAL.
REQ-027 SHALL leave o_* data fields unchanged when no load occurs; only o_valid is cleared by flush.

Reset
REQ-028 SHALL, on i_rst_n=0, immediately clear o_valid and all registered outputs to 0 independent of i_clk.
REQ-029 SHALL have o_ready=1 during and after reset; the first acceptance is on the first edge with i_rst_n=1.
REQ-030 SHALL discard an in-flight bundle on reset assertion mid-stall.

Structure
REQ-031 SHALL place opcode constants, ALU-ctrl encodings, and the immediate-format enum in shared package rv_pkg.
REQ-032 SHALL implement immediate generation as combinational sub-module imm_gen (XLEN parameter); ALU-control decode reuses the existing ALU decoder.

Verification
REQ-033 SHALL verify: 0xFFF00093 (addi x1,x0,-1), XLEN=32 -> next cycle o_valid=1, rd=1, o_imm=0xFFFFFFFF, o_rfwe=1, o_illegal=0.
REQ-034 SHALL verify: 0xFE000EE3 (beq -4) -> o_imm=0xFFFFFFFC, o_rfwe=0; with XLEN=64 -> 0xFFFFFFFFFFFFFFFC.
REQ-035 SHALL verify: i_ready=0 for 3 cycles with a new i_valid -> o_ready=0 and outputs unchanged; i_ready=1 -> next instruction appears the following cycle.
REQ-036 SHALL verify: i_flush=1 together with i_valid=1 -> o_valid=0 next cycle.
REQ-037 SHALL verify: 0x00000000 and 0x02000033 with EN_M=0 -> o_illegal=1, o_rfwe=0; 0x02000033 with EN_M=1 -> o_illegal=0.
REQ-038 SHALL verify: i_rst_n pulled low mid-stall -> o_valid=0 within the same cycle.

Source files
------------

// File: rtl/rv_pkg.sv
// Shared RISC-V decode definitions: opcodes, ALU control encodings, immediate
// formats, the registered control bundle and the ALU-control decoder.
package rv_pkg;

   localparam logic [6:0] OPC_LOAD     = 7'b0000011;
   localparam logic [6:0] OPC_MISC_MEM = 7'b0001111;
   localparam logic [6:0] OPC_OP_IMM   = 7'b0010011;
   localparam logic [6:0] OPC_AUIPC    = 7'b0010111;
   localparam logic [6:0] OPC_STORE    = 7'b0100011;
   localparam logic [6:0] OPC_OP       = 7'b0110011;
   localparam logic [6:0] OPC_LUI      = 7'b0110111;
   localparam logic [6:0] OPC_BRANCH   = 7'b1100011;
   localparam logic [6:0] OPC_JALR     = 7'b1100111;
   localparam logic [6:0] OPC_JAL      = 7'b1101111;
   localparam logic [6:0] OPC_SYSTEM   = 7'b1110011;

   localparam logic [6:0] F7_BASE = 7'h00;
   localparam logic [6:0] F7_ALT  = 7'h20;
   localparam logic [6:0] F7_MULDIV = 7'h01;

   typedef enum logic [3:0] {
      ALU_ADD    = 4'd0,
      ALU_SUB    = 4'd1,
      ALU_SLL    = 4'd2,
      ALU_SLT    = 4'd3,
      ALU_SLTU   = 4'd4,
      ALU_XOR    = 4'd5,
      ALU_SRL    = 4'd6,
      ALU_SRA    = 4'd7,
      ALU_OR     = 4'd8,
      ALU_AND    = 4'd9,
      ALU_PASSB  = 4'd10,
      ALU_MULDIV = 4'd11
   } alu_ctrl_e;

   typedef enum logic [2:0] {
      IMM_NONE,
      IMM_I,
      IMM_S,
      IMM_B,
      IMM_U,
      IMM_J,
      IMM_SH,
      IMM_CSR
   } imm_fmt_e;

   typedef struct packed {
      logic      rfwe;
      logic      mren;
      logic      mwen;
      logic      imm_rs;
      logic      pc_rs;
      logic      csrr;
      logic      illegal;
      alu_ctrl_e alu;
   } ctrl_t;

   // alt selects SUB (register form only) and SRA (both forms)
   function automatic alu_ctrl_e alu_dec(input logic [2:0] funct3,
                                         input logic       alt,
                                         input logic       is_reg);
      alu_ctrl_e res;
      res = ALU_ADD;
      case (funct3)
         3'b000:  res = (alt && is_reg) ? ALU_SUB : ALU_ADD;
         3'b001:  res = ALU_SLL;
         3'b010:  res = ALU_SLT;
         3'b011:  res = ALU_SLTU;
         3'b100:  res = ALU_XOR;
         3'b101:  res = alt ? ALU_SRA : ALU_SRL;
         3'b110:  res = ALU_OR;
         default: res = ALU_AND;
      endcase
      return res;
   endfunction

endpackage

// File: rtl/decode_stage_if.sv
// Upstream instruction handshake plus downstream decoded-bundle handshake.
interface decode_stage_if #(
   parameter int unsigned XLEN = 32
);
   logic            i_valid;
   logic            o_ready;
   logic [31:0]     i_inst;
   logic [XLEN-1:0] i_pc;
   logic            i_flush;
   logic            o_valid;
   logic            i_ready;
   logic [XLEN-1:0] o_pc;
   logic [4:0]      o_rd;
   logic [4:0]      o_rs1;
   logic [4:0]      o_rs2;
   logic [2:0]      o_funct3;
   logic [6:0]      o_funct7;
   logic [XLEN-1:0] o_imm;
   logic            o_rfwe;
   logic            o_mren;
   logic            o_mwen;
   logic            o_imm_rs;
   logic            o_pc_rs;
   logic            o_csrr;
   logic [3:0]      o_ctrl;
   logic            o_illegal;

   modport slave (
      input  i_valid, i_inst, i_pc, i_flush, i_ready,
      output o_ready, o_valid, o_pc, o_rd, o_rs1, o_rs2, o_funct3, o_funct7,
             o_imm, o_rfwe, o_mren, o_mwen, o_imm_rs, o_pc_rs, o_csrr,
             o_ctrl, o_illegal
   );

   modport master (
      output i_valid, i_inst, i_pc, i_flush, i_ready,
      input  o_ready, o_valid, o_pc, o_rd, o_rs1, o_rs2, o_funct3, o_funct7,
             o_imm, o_rfwe, o_mren, o_mwen, o_imm_rs, o_pc_rs, o_csrr,
             o_ctrl, o_illegal
   );
endinterface

// File: rtl/imm_gen.sv
// Combinational immediate generator; builds a 32-bit value and then extends
// it to XLEN using the format's extension bit.
module imm_gen
   import rv_pkg::*;
#(
   parameter int unsigned XLEN = 32
) (
   input  logic [31:0]     inst,
   input  imm_fmt_e        fmt,
   output logic [XLEN-1:0] imm
);

   logic [31:0] v;
   logic        sx;
   logic        sh_hi;

   assign sh_hi = (XLEN == 64) ? inst[25] : 1'b0;

   always_comb begin
      v  = '0;
      sx = 1'b0;
      case (fmt)
         IMM_I:   begin v = {{20{inst[31]}}, inst[31:20]};                                sx = inst[31]; end
         IMM_S:   begin v = {{20{inst[31]}}, inst[31:25], inst[11:7]};                    sx = inst[31]; end
         IMM_B:   begin v = {{20{inst[31]}}, inst[7], inst[30:25], inst[11:8], 1'b0};     sx = inst[31]; end
         IMM_U:   begin v = {inst[31:12], 12'b0};                                         sx = inst[31]; end
         IMM_J:   begin v = {{12{inst[31]}}, inst[19:12], inst[20], inst[30:21], 1'b0};   sx = inst[31]; end
         IMM_SH:  v = {26'b0, sh_hi, inst[24:20]};
         IMM_CSR: v = {27'b0, inst[19:15]};
         default: v = '0;
      endcase
      imm       = {XLEN{sx}};
      imm[31:0] = v;
   end

endmodule

// File: rtl/decode_stage.sv
// RV32/RV64 instruction decode stage: one registered decoded bundle with a
// valid/ready handshake on both sides and a flush that drops the bundle.
module decode_stage
   import rv_pkg::*;
#(
   parameter int unsigned XLEN   = 32,
   parameter bit          EN_M   = 1'b0,
   parameter bit          EN_CSR = 1'b1
) (
   input logic           i_clk,
   input logic           i_rst_n,
   decode_stage_if.slave bus
);

   logic [6:0]      opcode;
   logic [2:0]      funct3;
   logic [6:0]      funct7;
   logic [4:0]      rd;
   logic            shamt_ok;
   imm_fmt_e        fmt;
   ctrl_t           ctrl_d;
   logic [XLEN-1:0] imm_d;

   logic            valid_q;
   logic [XLEN-1:0] pc_q;
   logic [XLEN-1:0] imm_q;
   logic [4:0]      rd_q;
   logic [4:0]      rs1_q;
   logic [4:0]      rs2_q;
   logic [2:0]      funct3_q;
   logic [6:0]      funct7_q;
   ctrl_t           ctrl_q;

   logic            ready;
   logic            load;

   assign opcode = bus.i_inst[6:0];
   assign funct3 = bus.i_inst[14:12];
   assign funct7 = bus.i_inst[31:25];
   assign rd     = bus.i_inst[11:7];

   // RV64 shift amounts borrow inst[25], so only inst[31:26] are qualifier bits
   always_comb begin
      shamt_ok = 1'b1;
      if (XLEN == 64) begin
         if (funct3 == 3'b001)
            shamt_ok = (bus.i_inst[31:26] == 6'b000000);
         else if (funct3 == 3'b101)
            shamt_ok = (bus.i_inst[31:26] == 6'b000000) || (bus.i_inst[31:26] == 6'b010000);
      end else begin
         if (funct3 == 3'b001)
            shamt_ok = (funct7 == F7_BASE);
         else if (funct3 == 3'b101)
            shamt_ok = (funct7 == F7_BASE) || (funct7 == F7_ALT);
      end
   end

   always_comb begin
      logic legal;
      legal       = (bus.i_inst[1:0] == 2'b11);
      fmt         = IMM_NONE;
      ctrl_d      = '0;
      ctrl_d.alu  = ALU_ADD;
      case (opcode)
         OPC_LUI: begin
            ctrl_d.rfwe = 1'b1;
            ctrl_d.alu  = ALU_PASSB;
            fmt         = IMM_U;
         end
         OPC_AUIPC: begin
            ctrl_d.rfwe  = 1'b1;
            ctrl_d.pc_rs = 1'b1;
            fmt          = IMM_U;
         end
         OPC_JAL: begin
            ctrl_d.rfwe   = 1'b1;
            ctrl_d.pc_rs  = 1'b1;
            ctrl_d.imm_rs = 1'b1;
            fmt           = IMM_J;
         end
         OPC_JALR: begin
            ctrl_d.rfwe   = 1'b1;
            ctrl_d.pc_rs  = 1'b1;
            ctrl_d.imm_rs = 1'b1;
            fmt           = IMM_I;
            if (funct3 != 3'b000) legal = 1'b0;
         end
         OPC_BRANCH: begin
            ctrl_d.alu = ALU_SUB;
            fmt        = IMM_B;
            if (funct3[2:1] == 2'b01) legal = 1'b0;
         end
         OPC_LOAD: begin
            ctrl_d.rfwe   = 1'b1;
            ctrl_d.mren   = 1'b1;
            ctrl_d.imm_rs = 1'b1;
            fmt           = IMM_I;
            if (funct3 == 3'b111) legal = 1'b0;
            if ((XLEN == 32) && ((funct3 == 3'b011) || (funct3 == 3'b110))) legal = 1'b0;
         end
         OPC_STORE: begin
            ctrl_d.mwen   = 1'b1;
            ctrl_d.imm_rs = 1'b1;
            fmt           = IMM_S;
            if (funct3[2]) legal = 1'b0;
            if ((XLEN == 32) && (funct3 == 3'b011)) legal = 1'b0;
         end
         OPC_OP_IMM: begin
            ctrl_d.rfwe   = 1'b1;
            ctrl_d.imm_rs = 1'b1;
            ctrl_d.alu    = alu_dec(funct3, bus.i_inst[30], 1'b0);
            fmt           = (funct3[1:0] == 2'b01) ? IMM_SH : IMM_I;
            if (!shamt_ok) legal = 1'b0;
         end
         OPC_OP: begin
            ctrl_d.rfwe = 1'b1;
            if (funct7 == F7_BASE)
               ctrl_d.alu = alu_dec(funct3, 1'b0, 1'b1);
            else if ((funct7 == F7_ALT) && ((funct3 == 3'b000) || (funct3 == 3'b101)))
               ctrl_d.alu = alu_dec(funct3, 1'b1, 1'b1);
            else if (EN_M && (funct7 == F7_MULDIV))
               ctrl_d.alu = ALU_MULDIV;
            else
               legal = 1'b0;
         end
         OPC_MISC_MEM: ;
         OPC_SYSTEM: begin
            if (!EN_CSR || (funct3 == 3'b100)) begin
               legal = 1'b0;
            end else if (funct3 != 3'b000) begin
               ctrl_d.rfwe = 1'b1;
               ctrl_d.csrr = 1'b1;
               fmt         = IMM_CSR;
            end
         end
         default: legal = 1'b0;
      endcase
      if (rd == 5'd0) ctrl_d.rfwe = 1'b0;
      if (!legal) begin
         ctrl_d.rfwe = 1'b0;
         ctrl_d.mren = 1'b0;
         ctrl_d.mwen = 1'b0;
      end
      ctrl_d.illegal = !legal;
   end

   imm_gen #(.XLEN(XLEN)) u_imm_gen (
      .inst (bus.i_inst),
      .fmt  (fmt),
      .imm  (imm_d)
   );

   assign ready = !valid_q || bus.i_ready;
   assign load  = bus.i_valid && ready && !bus.i_flush;

   // Flush only drops valid; the data registers keep their last loaded bundle
   always_ff @(posedge i_clk or negedge i_rst_n) begin
      if (!i_rst_n) begin
         valid_q  <= 1'b0;
         pc_q     <= '0;
         imm_q    <= '0;
         rd_q     <= '0;
         rs1_q    <= '0;
         rs2_q    <= '0;
         funct3_q <= '0;
         funct7_q <= '0;
         ctrl_q   <= '0;
      end else begin
         if (bus.i_flush)
            valid_q <= 1'b0;
         else if (ready)
            valid_q <= bus.i_valid;
         if (load) begin
            pc_q     <= bus.i_pc;
            imm_q    <= imm_d;
            rd_q     <= rd;
            rs1_q    <= bus.i_inst[19:15];
            rs2_q    <= bus.i_inst[24:20];
            funct3_q <= funct3;
            funct7_q <= funct7;
            ctrl_q   <= ctrl_d;
         end
      end
   end

   assign bus.o_ready   = ready;
   assign bus.o_valid   = valid_q;
   assign bus.o_pc      = pc_q;
   assign bus.o_imm     = imm_q;
   assign bus.o_rd      = rd_q;
   assign bus.o_rs1     = rs1_q;
   assign bus.o_rs2     = rs2_q;
   assign bus.o_funct3  = funct3_q;
   assign bus.o_funct7  = funct7_q;
   assign bus.o_rfwe    = ctrl_q.rfwe;
   assign bus.o_mren    = ctrl_q.mren;
   assign bus.o_mwen    = ctrl_q.mwen;
   assign bus.o_imm_rs  = ctrl_q.imm_rs;
   assign bus.o_pc_rs   = ctrl_q.pc_rs;
   assign bus.o_csrr    = ctrl_q.csrr;
   assign bus.o_ctrl    = ctrl_q.alu;
   assign bus.o_illegal = ctrl_q.illegal;

endmodule

// File: tb/tb_decode_stage.sv
// Directed bench: an RV32 (EN_M=0, EN_CSR=1) and an RV64 (EN_M=1, EN_CSR=0)
// decode stage driven with the same instruction stream.
module tb_decode_stage;

   logic clk = 1'b0;
   logic rst_n;
   int   n_checks = 0;
   int   n_errors = 0;

   always #5 clk = ~clk;

   decode_stage_if #(.XLEN(32)) b32 ();
   decode_stage_if #(.XLEN(64)) b64 ();

   decode_stage #(.XLEN(32), .EN_M(1'b0), .EN_CSR(1'b1)) dut32 (
      .i_clk   (clk),
      .i_rst_n (rst_n),
      .bus     (b32)
   );

   decode_stage #(.XLEN(64), .EN_M(1'b1), .EN_CSR(1'b0)) dut64 (
      .i_clk   (clk),
      .i_rst_n (rst_n),
      .bus     (b64)
   );

   task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_errors++;
         $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
      end
   endtask

   task automatic drive(input logic v, input logic [31:0] inst, input logic [31:0] pc,
                        input logic fl, input logic rdy);
      b32.i_valid = v;   b64.i_valid = v;
      b32.i_inst  = inst; b64.i_inst = inst;
      b32.i_pc    = pc;  b64.i_pc    = {32'h0, pc};
      b32.i_flush = fl;  b64.i_flush = fl;
      b32.i_ready = rdy; b64.i_ready = rdy;
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   initial begin
      #100000;
      $display("FAIL timeout: simulation did not finish");
      $fatal(1);
   end

   initial begin
      rst_n = 1'b0;
      drive(1'b0, 32'h0, 32'h0, 1'b0, 1'b1);
      #2;
      check("rst_valid32", b32.o_valid, 0);
      check("rst_valid64", b64.o_valid, 0);
      check("rst_ready32", b32.o_ready, 1);
      check("rst_imm64",   b64.o_imm, 0);
      check("rst_rfwe32",  b32.o_rfwe, 0);
      repeat (2) @(posedge clk);
      @(negedge clk);
      rst_n = 1'b1;
      #1;
      check("post_rst_ready", b32.o_ready, 1);

      // addi x1, x0, -1
      drive(1'b1, 32'hFFF00093, 32'h100, 1'b0, 1'b1);
      tick();
      check("addi_valid",   b32.o_valid, 1);
      check("addi_rd",      b32.o_rd, 1);
      check("addi_imm32",   b32.o_imm, 64'hFFFFFFFF);
      check("addi_imm64",   b64.o_imm, 64'hFFFFFFFFFFFFFFFF);
      check("addi_rfwe",    b32.o_rfwe, 1);
      check("addi_illegal", b32.o_illegal, 0);
      check("addi_imm_rs",  b32.o_imm_rs, 1);
      check("addi_pc",      b32.o_pc, 64'h100);

      // beq x0, x0, -4
      drive(1'b1, 32'hFE000EE3, 32'h104, 1'b0, 1'b1);
      tick();
      check("beq_valid", b32.o_valid, 1);
      check("beq_imm32", b32.o_imm, 64'hFFFFFFFC);
      check("beq_imm64", b64.o_imm, 64'hFFFFFFFFFFFFFFFC);
      check("beq_rfwe",  b32.o_rfwe, 0);
      check("beq_ctrl",  b32.o_ctrl, 1);
      check("beq_pc64",  b64.o_pc, 64'h104);

      // sw x5, -8(x2)
      drive(1'b1, 32'hFE512C23, 32'h108, 1'b0, 1'b1);
      tick();
      check("sw_imm",    b32.o_imm, 64'hFFFFFFF8);
      check("sw_mwen",   b32.o_mwen, 1);
      check("sw_rfwe",   b32.o_rfwe, 0);
      check("sw_rs1",    b32.o_rs1, 2);
      check("sw_rs2",    b32.o_rs2, 5);
      check("sw_funct3", b32.o_funct3, 2);

      // lui x3, 0x80000
      drive(1'b1, 32'h800001B7, 32'h10C, 1'b0, 1'b1);
      tick();
      check("lui_imm32", b32.o_imm, 64'h80000000);
      check("lui_imm64", b64.o_imm, 64'hFFFFFFFF80000000);
      check("lui_rd",    b32.o_rd, 3);
      check("lui_rfwe",  b32.o_rfwe, 1);

      // jal x1, +2048
      drive(1'b1, 32'h001000EF, 32'h110, 1'b0, 1'b1);
      tick();
      check("jal_imm",    b32.o_imm, 64'h800);
      check("jal_pc_rs",  b32.o_pc_rs, 1);
      check("jal_imm_rs", b32.o_imm_rs, 1);
      check("jal_rfwe",   b32.o_rfwe, 1);

      // srai x1, x1, 3
      drive(1'b1, 32'h4030D093, 32'h114, 1'b0, 1'b1);
      tick();
      check("srai_imm",     b32.o_imm, 3);
      check("srai_ctrl",    b32.o_ctrl, 7);
      check("srai_illegal", b32.o_illegal, 0);

      // srai x1, x1, 35: only legal on RV64
      drive(1'b1, 32'h4230D093, 32'h118, 1'b0, 1'b1);
      tick();
      check("srai35_ill32",  b32.o_illegal, 1);
      check("srai35_rfwe32", b32.o_rfwe, 0);
      check("srai35_ill64",  b64.o_illegal, 0);
      check("srai35_imm64",  b64.o_imm, 35);

      // csrrwi x1, 0x300, 31: CSR decode enabled on RV32 only
      drive(1'b1, 32'h300FD0F3, 32'h11C, 1'b0, 1'b1);
      tick();
      check("csr_imm32",   b32.o_imm, 31);
      check("csr_csrr32",  b32.o_csrr, 1);
      check("csr_ill32",   b32.o_illegal, 0);
      check("csr_ill64",   b64.o_illegal, 1);
      check("csr_rfwe64",  b64.o_rfwe, 0);

      // all-zero word
      drive(1'b1, 32'h00000000, 32'h120, 1'b0, 1'b1);
      tick();
      check("zero_ill32",  b32.o_illegal, 1);
      check("zero_rfwe32", b32.o_rfwe, 0);
      check("zero_ill64",  b64.o_illegal, 1);
      check("zero_mren64", b64.o_mren, 0);

      // mul x0, x0, x0
      drive(1'b1, 32'h02000033, 32'h124, 1'b0, 1'b1);
      tick();
      check("mul_ill32",  b32.o_illegal, 1);
      check("mul_rfwe32", b32.o_rfwe, 0);
      check("mul_ill64",  b64.o_illegal, 0);
      check("mul_ctrl64", b64.o_ctrl, 11);

      // bubble: valid drops, fields hold
      drive(1'b0, 32'hFFF00093, 32'h128, 1'b0, 1'b1);
      tick();
      check("idle_valid",  b32.o_valid, 0);
      check("idle_funct7", b32.o_funct7, 7'h01);
      check("idle_pc",     b32.o_pc, 64'h124);

      // stall: hold addi while lui waits upstream
      drive(1'b1, 32'hFFF00093, 32'h200, 1'b0, 1'b0);
      tick();
      check("stall_load_valid", b32.o_valid, 1);
      drive(1'b1, 32'h123451B7, 32'h204, 1'b0, 1'b0);
      for (int i = 0; i < 3; i++) begin
         tick();
         check("stall_ready", b32.o_ready, 0);
         check("stall_valid", b32.o_valid, 1);
         check("stall_rd",    b32.o_rd, 1);
         check("stall_imm",   b32.o_imm, 64'hFFFFFFFF);
         check("stall_pc",    b32.o_pc, 64'h200);
      end
      drive(1'b1, 32'h123451B7, 32'h204, 1'b0, 1'b1);
      #1;
      check("unstall_ready", b32.o_ready, 1);
      tick();
      check("unstall_rd",    b32.o_rd, 3);
      check("unstall_imm",   b32.o_imm, 64'h12345000);
      check("unstall_pc",    b32.o_pc, 64'h204);
      check("unstall_valid", b32.o_valid, 1);
      drive(1'b0, 32'h0, 32'h0, 1'b0, 1'b1);
      tick();
      check("drain_valid", b32.o_valid, 0);

      // flush with an incoming instruction
      drive(1'b1, 32'hFFF00093, 32'h300, 1'b1, 1'b1);
      tick();
      check("flush_in_valid32", b32.o_valid, 0);
      check("flush_in_valid64", b64.o_valid, 0);
      check("flush_in_pc",      b32.o_pc, 64'h204);

      // flush while holding a stalled bundle
      drive(1'b1, 32'hFFF00093, 32'h300, 1'b0, 1'b0);
      tick();
      check("flush_hold_pre", b32.o_valid, 1);
      drive(1'b1, 32'h123451B7, 32'h304, 1'b1, 1'b0);
      tick();
      check("flush_hold_valid", b32.o_valid, 0);
      check("flush_hold_pc",    b32.o_pc, 64'h300);

      // asynchronous reset in the middle of a stall
      drive(1'b1, 32'hFFF00093, 32'h400, 1'b0, 1'b0);
      tick();
      check("mid_rst_pre", b64.o_valid, 1);
      drive(1'b1, 32'h123451B7, 32'h404, 1'b0, 1'b0);
      #2;
      rst_n = 1'b0;
      #1;
      check("mid_rst_valid32", b32.o_valid, 0);
      check("mid_rst_valid64", b64.o_valid, 0);
      check("mid_rst_imm",     b32.o_imm, 0);
      check("mid_rst_ready",   b32.o_ready, 1);
      drive(1'b0, 32'h0, 32'h0, 1'b0, 1'b1);
      tick();
      @(negedge clk);
      rst_n = 1'b1;
      tick();
      check("after_rst_valid", b32.o_valid, 0);

      $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
      $finish;
   end

endmodule
